// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter: shares the SDRAM core between the display reader and
// two round-robin writers, with a read starvation cap and a watchdog.
module sdram_rw_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_done,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_done,
  output logic [1:0]        sdram_call,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_wdata,
  input  logic [1:0]        sdram_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT
  } state_e;

  typedef enum logic [1:0] {
    G_RD, G_WR0, G_WR1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  logic [1:0]        call_q, call_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              rr_q, rr_d;
  logic              terr_q, terr_d;
  logic              rdd_q, rdd_d;
  logic              w0d_q, w0d_d;
  logic              w1d_q, w1d_d;

  logic wr_pend, rd_win, wr0_win, wr1_win, hit;

  always_comb begin
    wr_pend = wr0_req | wr1_req;
    rd_win  = rd_req &
              ((starve_q < SW'(STARVE_MAX)) | ~wr_pend);
    // rr_q = 0 prefers wr0, 1 prefers wr1
    wr0_win = ~rd_win & wr0_req & (~rr_q | ~wr1_req);
    wr1_win = ~rd_win & wr1_req & ~wr0_win;
    hit     = (gnt_q == G_RD) ? sdram_done[0]
                              : sdram_done[1];
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    call_d   = call_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    rr_d     = rr_q;
    terr_d   = terr_q;
    rdd_d    = 1'b0;
    w0d_d    = 1'b0;
    w1d_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en && (rd_req || wr_pend)) begin
          state_d = S_ISSUE;
          unique case (1'b1)
            rd_win: begin
              gnt_d  = G_RD;
              addr_d = rd_addr;
              if (!wr_pend) begin
                starve_d = '0;
              end else if (starve_q != SW'(STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
              end
            end
            wr0_win: begin
              gnt_d    = G_WR0;
              addr_d   = wr0_addr;
              wdata_d  = wr0_data;
              starve_d = '0;
              rr_d     = 1'b1;
            end
            wr1_win: begin
              gnt_d    = G_WR1;
              addr_d   = wr1_addr;
              wdata_d  = wr1_data;
              starve_d = '0;
              rr_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        call_d  = (gnt_q == G_RD) ? 2'b01 : 2'b10;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit) begin
          call_d  = 2'b00;
          rdd_d   = (gnt_q == G_RD);
          w0d_d   = (gnt_q == G_WR0);
          w1d_d   = (gnt_q == G_WR1);
          state_d = S_IDLE;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          // call has been held TIMEOUT cycles; abandon it
          call_d  = 2'b00;
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= G_RD;
      call_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      wd_q     <= '0;
      rr_q     <= 1'b0;
      terr_q   <= 1'b0;
      rdd_q    <= 1'b0;
      w0d_q    <= 1'b0;
      w1d_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      call_q   <= call_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      rr_q     <= rr_d;
      terr_q   <= terr_d;
      rdd_q    <= rdd_d;
      w0d_q    <= w0d_d;
      w1d_q    <= w1d_d;
    end
  end

  assign sdram_call  = call_q;
  assign sdram_addr  = addr_q;
  assign sdram_wdata = wdata_q;
  assign rd_done     = rdd_q;
  assign wr0_done    = w0d_q;
  assign wr1_done    = w1d_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// tb_sdram_rw_arbiter: random requesters and core model, scoreboard of
// predicted grants checked by an independent monitor.
module tb_sdram_rw_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SM = 8;
  localparam int TO = 1023;

  logic          clk;
  logic          rst_n;
  logic          en_v;
  logic          q_v [3];
  logic [AW-1:0] a_v [3];
  logic [DW-1:0] d_v [3];
  logic [1:0]    done_v;

  logic          rd_done, wr0_done, wr1_done;
  logic [1:0]    sdram_call;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_wdata;
  logic          busy, timeout_err;

  sdram_rw_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_MAX(SM), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en_v),
    .rd_req(q_v[0]),
    .rd_addr(a_v[0]),
    .rd_done(rd_done),
    .wr0_req(q_v[1]),
    .wr0_addr(a_v[1]),
    .wr0_data(d_v[1]),
    .wr0_done(wr0_done),
    .wr1_req(q_v[2]),
    .wr1_addr(a_v[2]),
    .wr1_data(d_v[2]),
    .wr1_done(wr1_done),
    .sdram_call(sdram_call),
    .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata),
    .sdram_done(done_v),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // requester and core-model controls
  bit act [3];
  bit hold [3];
  int gap [3];
  bit en_rand, en_fix, spur, no_done;
  bit c_busy, c_fired;
  int c_dly;

  task automatic drive_step();
    logic [2:0] dn;
    dn = {wr1_done, wr0_done, rd_done};
    for (int s = 0; s < 3; s++) begin
      if (!act[s]) begin
        q_v[s] = 1'b0;
      end else if (q_v[s]) begin
        if (!hold[s] &&
            (dn[s] || $urandom_range(0, 31) == 0)) begin
          q_v[s] = 1'b0;
          gap[s] = $urandom_range(0, 3);
        end
      end else if (gap[s] > 0) begin
        gap[s]--;
      end else begin
        q_v[s] = 1'b1;
        a_v[s] = AW'($urandom);
        d_v[s] = DW'($urandom);
      end
    end
    en_v = en_rand ? ($urandom_range(0, 3) != 0) : en_fix;
    done_v = 2'b00;
    if (sdram_call == 2'b00) begin
      c_busy = 1'b0;
    end else if (!c_busy) begin
      c_busy  = 1'b1;
      c_fired = 1'b0;
      c_dly   = $urandom_range(1, 6);
    end
    if (c_busy && !c_fired && !no_done) begin
      if (c_dly == 0) begin
        done_v  = sdram_call;
        c_fired = 1'b1;
      end else begin
        c_dly--;
      end
    end
    if (spur && sdram_call != 2'b00 &&
        $urandom_range(0, 3) == 0)
      done_v = done_v | ~sdram_call;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      drive_step();
    end
  end

  // what the DUT sampled at the last rising edge
  logic          s_rst, s_en;
  logic          s_req [3];
  logic [AW-1:0] s_addr [3];
  logic [DW-1:0] s_data [3];
  logic [1:0]    s_done;

  always @(posedge clk) begin
    s_rst  = rst_n;
    s_en   = en_v;
    s_done = done_v;
    for (int s = 0; s < 3; s++) begin
      s_req[s]  = q_v[s];
      s_addr[s] = a_v[s];
      s_data[s] = d_v[s];
    end
  end

  typedef struct {
    int            src;
    logic [1:0]    call;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   starve, rr, owner, wcnt;
  bit   terr_e, busy_p;
  logic [1:0]    call_p;
  logic [AW-1:0] addr_p;
  logic [DW-1:0] wd_p;

  // arbitration rules applied to one sampled request set
  function automatic exp_t predict();
    exp_t r;
    bit anyw;
    anyw = s_req[1] | s_req[2];
    if (s_req[0] && (starve < SM || !anyw)) begin
      r.src  = 0;
      starve = anyw ? ((starve < SM) ? starve + 1 : SM) : 0;
    end else begin
      r.src  = s_req[1 + rr] ? 1 + rr : 2 - rr;
      starve = 0;
      rr     = (r.src == 1) ? 1 : 0;
    end
    r.call = (r.src == 0) ? 2'b01 : 2'b10;
    r.addr = s_addr[r.src];
    r.data = s_data[r.src];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [2:0] dn;
    bit hit;
    dn = {wr1_done, wr0_done, rd_done};
    if (!rst_n || !s_rst) begin
      exp_q.delete();
      starve = 0;
      rr     = 0;
      terr_e = 0;
      busy_p = 0;
      call_p = 2'b00;
      wcnt   = 0;
    end else begin
      hit = (call_p == 2'b01 && s_done[0]) ||
            (call_p == 2'b10 && s_done[1]);
      chk(sdram_call != 2'b11, "call_11", sdram_call, 0);
      if (call_p == 2'b00 && sdram_call != 2'b00) begin
        chk(exp_q.size() != 0, "call_unexp",
            sdram_call, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(sdram_call == e.call, "call_val",
              sdram_call, e.call);
          chk(sdram_addr == e.addr, "addr",
              sdram_addr, e.addr);
          if (e.src != 0)
            chk(sdram_wdata == e.data, "wdata",
                sdram_wdata, e.data);
          owner = e.src;
          wcnt  = 1;
        end
        chk(dn == 3'b000, "done_rise", dn, 0);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(sdram_call == e.call, "call_late",
            sdram_call, e.call);
        chk(dn == 3'b000, "done_issue", dn, 0);
      end else if (call_p != 2'b00 && sdram_call != 2'b00) begin
        chk(!hit, "done_not_taken", sdram_call, 0);
        chk(sdram_call == call_p && sdram_addr == addr_p &&
            sdram_wdata == wd_p, "hold", sdram_addr, addr_p);
        chk(dn == 3'b000, "done_wait", dn, 0);
        wcnt++;
      end else if (call_p != 2'b00) begin
        if (hit) begin
          chk(dn == (3'b001 << owner), "done_pulse",
              dn, 3'b001 << owner);
        end else begin
          chk(wcnt == TO, "timeout_len", wcnt, TO);
          chk(dn == 3'b000, "done_on_to", dn, 0);
          terr_e = 1;
        end
      end else begin
        chk(dn == 3'b000, "done_idle", dn, 0);
      end
      if (!busy_p) begin
        if (s_en && (s_req[0] || s_req[1] || s_req[2])) begin
          chk(busy == 1'b1, "grant_miss", busy, 1);
          if (busy) exp_q.push_back(predict());
        end else begin
          chk(busy == 1'b0, "grant_bad", busy, 0);
        end
      end
      chk(timeout_err == terr_e, "timeout_err",
          timeout_err, terr_e);
      busy_p = busy;
    end
    call_p = sdram_call;
    addr_p = sdram_addr;
    wd_p   = sdram_wdata;
  end

  task automatic set_mode(input bit a0, input bit a1,
                          input bit a2, input bit h);
    act[0] = a0; act[1] = a1; act[2] = a2;
    for (int s = 0; s < 3; s++) hold[s] = h;
  endtask

  task automatic chk_zero(input string nm);
    chk(sdram_call == 2'b00, {nm, "_call"}, sdram_call, 0);
    chk(sdram_addr == '0, {nm, "_addr"}, sdram_addr, 0);
    chk(sdram_wdata == '0, {nm, "_wdata"}, sdram_wdata, 0);
    chk({rd_done, wr0_done, wr1_done} == 3'b000,
        {nm, "_done"}, {rd_done, wr0_done, wr1_done}, 0);
    chk(busy == 1'b0, {nm, "_busy"}, busy, 0);
    chk(timeout_err == 1'b0, {nm, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    en_v = 1'b0;
    done_v = 2'b00;
    for (int s = 0; s < 3; s++) begin
      q_v[s] = 1'b0; a_v[s] = '0; d_v[s] = '0;
      gap[s] = 0;
    end
    set_mode(0, 0, 0, 0);
    en_rand = 0; en_fix = 1; spur = 0; no_done = 0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    #2 rst_n = 1'b1;

    set_mode(1, 0, 0, 0);
    repeat (150) @(negedge clk);
    set_mode(1, 1, 1, 1);
    repeat (300) @(negedge clk);
    set_mode(0, 1, 1, 0);
    repeat (200) @(negedge clk);

    en_fix = 0;
    set_mode(1, 1, 1, 0);
    repeat (40) @(negedge clk);
    chk(busy == 1'b0, "en0_idle", busy, 0);
    en_fix = 1;
    @(negedge clk);
    @(negedge clk);
    chk(busy == 1'b1, "en1_grant", busy, 1);

    en_rand = 1; spur = 1;
    repeat (3000) @(negedge clk);
    en_rand = 0; spur = 0;

    set_mode(1, 0, 0, 1);
    no_done = 1;
    repeat (1100) @(negedge clk);
    chk(timeout_err == 1'b1, "t4_terr", timeout_err, 1);
    no_done = 0;
    repeat (60) @(negedge clk);
    chk(timeout_err == 1'b1, "t4_sticky", timeout_err, 1);

    set_mode(0, 1, 1, 1);
    no_done = 1;
    for (k = 0; k < 400 && sdram_call != 2'b10; k++)
      @(negedge clk);
    chk(sdram_call == 2'b10, "t5_wait", sdram_call, 2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_rst");
    @(negedge clk);
    no_done = 0;
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk(sdram_call == 2'b10, "t5_regrant", sdram_call, 2);

    set_mode(1, 1, 1, 0);
    en_rand = 1; spur = 1;
    repeat (600) @(negedge clk);

    en_rand = 0; spur = 0;
    set_mode(0, 0, 0, 0);
    repeat (30) @(negedge clk);
    chk(busy == 1'b0, "drain_busy", busy, 0);
    chk(exp_q.size() == 0, "drain_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
